// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings and compute-op detection, also
// imported by the control decoder and the hazard unit.
package mdu_defs;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MFHI     = 4'd5,
    MFLO     = 4'd6,
    MTHI     = 4'd7,
    MTLO     = 4'd8
  } mdu_op_e;

  // bit i set => op encoding i occupies the unit for a busy period
  localparam logic [15:0] MDU_COMPUTE_MASK = 16'b0000_0000_0001_1110;

  function automatic logic is_compute(input mdu_op_e op);
    return MDU_COMPUTE_MASK[op];
  endfunction

endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV into temps,
// commit to HI/LO at the end of the busy period, plus MF/MT access.
module mdu
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] mdu_result
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_t_q, hi_t_d, lo_t_q, lo_t_d;
  logic               commit_q, commit_d;

  mdu_op_e            op;
  logic               compute, is_mul, div_zero;
  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic signed [32:0] a_s, b_s, q_s, r_s;
  logic [31:0]        b_u, q_u, r_u;

  // 33-bit signed divide keeps INT_MIN / -1 well defined (wraps to INT_MIN);
  // a zero divisor is swapped for 1 so the datapath never produces X.
  always_comb begin
    op       = mdu_op_e'(mdu_op);
    compute  = is_compute(op);
    is_mul   = (op == MULT) || (op == MULTU);
    div_zero = (B == 32'd0);
    mul_s    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    mul_u    = {32'd0, A} * {32'd0, B};
    a_s      = $signed({A[31], A});
    b_s      = div_zero ? 33'sd1 : $signed({B[31], B});
    q_s      = a_s / b_s;
    r_s      = a_s % b_s;
    b_u      = div_zero ? 32'd1 : B;
    q_u      = A / b_u;
    r_u      = A % b_u;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_t_d   = hi_t_q;
    lo_t_d   = lo_t_q;
    commit_d = commit_q;
    case (state_q)
      S_IDLE: begin
        if (start && compute) begin
          case (op)
            MULT:    {hi_t_d, lo_t_d} = mul_s;
            MULTU:   {hi_t_d, lo_t_d} = mul_u;
            DIV:     begin lo_t_d = q_s[31:0]; hi_t_d = r_s[31:0]; end
            default: begin lo_t_d = q_u; hi_t_d = r_u; end
          endcase
          cnt_d    = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          commit_d = is_mul || !div_zero;
          state_d  = S_RUN;
        end else if (start && op == MTHI) begin
          hi_d = A;
        end else if (start && op == MTLO) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (commit_q) begin
            hi_d = hi_t_q;
            lo_d = lo_t_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_t_q   <= '0;
      lo_t_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_t_q   <= hi_t_d;
      lo_t_q   <= lo_t_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    busy   = (start && compute) || (state_q == S_RUN);
    HI_out = hi_q;
    LO_out = lo_q;
    case (op)
      MFHI:    mdu_result = hi_q;
      MFLO:    mdu_result = lo_q;
      default: mdu_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic reference model.
module tb_mdu;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI_out, LO_out, mdu_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .busy(busy), .HI_out(HI_out), .LO_out(LO_out), .mdu_result(mdu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // architectural result of a compute op; divide by zero leaves HI/LO alone
  task automatic ref_compute(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                             inout logic [31:0] hi, inout logic [31:0] lo);
    longint p, q, r;
    longint unsigned pu;
    case (op)
      MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32]; lo = p[31:0];
      end
      MULTU: begin
        pu = 64'(a) * 64'(b);
        hi = pu[63:32]; lo = pu[31:0];
      end
      DIV: if (b != 0) begin
        q  = longint'($signed(a)) / longint'($signed(b));
        r  = longint'($signed(a)) % longint'($signed(b));
        lo = q[31:0]; hi = r[31:0];
      end
      DIVU: if (b != 0) begin
        lo = a / b; hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue in the current cycle, then walk the whole busy period
  task automatic do_compute(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
    int n;
    logic [31:0] old_hi, old_lo;
    n = (op == MULT || op == MULTU) ? 5 : 10;
    old_hi = m_hi;
    old_lo = m_lo;
    ref_compute(op, a, b, m_hi, m_lo);
    start = 1'b1; mdu_op = op; A = a; B = b;
    #1;
    chk({tag, "/busy_T"}, 32'(busy), 32'd1);
    tick();
    start = 1'b0; mdu_op = MFHI; A = $urandom; B = $urandom;
    for (int k = 1; k <= n; k++) begin
      #1;
      chk({tag, "/busy_run"}, 32'(busy), 32'd1);
      chk({tag, "/hi_hold"}, mdu_result, old_hi);
      chk({tag, "/lo_hold"}, LO_out, old_lo);
      tick();
    end
    #1;
    chk({tag, "/busy_done"}, 32'(busy), 32'd0);
    chk({tag, "/mfhi"}, mdu_result, m_hi);
    mdu_op = MFLO;
    #1;
    chk({tag, "/mflo"}, mdu_result, m_lo);
    chk({tag, "/hi_out"}, HI_out, m_hi);
  endtask

  task automatic do_mt(input mdu_op_e op, input logic [31:0] a, input string tag);
    logic [31:0] other;
    start = 1'b1; mdu_op = op; A = a; B = $urandom;
    #1;
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    if (op == MTHI) begin m_hi = a; other = m_lo; mdu_op = MFHI; end
    else begin m_lo = a; other = m_hi; mdu_op = MFLO; end
    #1;
    chk({tag, "/mf"}, mdu_result, a);
    chk({tag, "/other"}, (op == MTHI) ? LO_out : HI_out, other);
    chk({tag, "/busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = MDU_NONE; A = '0; B = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst/hi", HI_out, 32'd0);
    chk("rst/lo", LO_out, 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/result_none", mdu_result, 32'd0);

    do_mt(MTHI, 32'hCAFE_0001, "mthi0");
    do_compute(MULT,  32'hFFFF_FFFD, 32'd7, "mult_neg");
    chk("mult_neg/hi", HI_out, 32'hFFFF_FFFF);
    chk("mult_neg/lo", LO_out, 32'hFFFF_FFEB);
    do_compute(MULTU, 32'hFFFF_FFFF, 32'd2, "multu");   // back-to-back, no gap
    chk("multu/hi", HI_out, 32'd1);
    chk("multu/lo", LO_out, 32'hFFFF_FFFE);
    do_compute(DIV,   32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg/lo", LO_out, 32'hFFFF_FFFD);
    chk("div_neg/hi", HI_out, 32'hFFFF_FFFF);
    do_compute(DIVU,  32'd7, 32'd0, "divu_zero");
    chk("divu_zero/hi", HI_out, 32'hFFFF_FFFF);
    do_compute(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf/lo", LO_out, 32'h8000_0000);
    do_mt(MTLO, 32'h0000_1234, "mtlo");
    mdu_op = MDU_NONE;
    #1;
    chk("none/result", mdu_result, 32'd0);

    // reset during RUN aborts and clears
    do_mt(MTHI, 32'h0000_DEAD, "pre_rst_hi");
    start = 1'b1; mdu_op = DIV; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run/busy", 32'(busy), 32'd0);
    chk("rst_run/hi", HI_out, 32'd0);
    chk("rst_run/lo", LO_out, 32'd0);
    repeat (12) tick();
    chk("rst_run/hi_late", HI_out, 32'd0);
    chk("rst_run/lo_late", LO_out, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // starts while busy are ignored
    start = 1'b1; mdu_op = DIV; A = 32'd100; B = 32'd7;
    tick();
    for (int k = 1; k <= 10; k++) begin
      start = (k == 2 || k == 3);
      mdu_op = (k == 2) ? MULT : MTHI;
      A = 32'h0000_5555; B = 32'd3;
      #1;
      chk("ign/busy", 32'(busy), 32'd1);
      chk("ign/hi_hold", HI_out, 32'd0);
      tick();
    end
    start = 1'b0; mdu_op = MDU_NONE;
    #1;
    chk("ign/busy_done", 32'(busy), 32'd0);
    chk("ign/hi", HI_out, 32'd2);
    chk("ign/lo", LO_out, 32'd14);
    m_hi = 32'd2; m_lo = 32'd14;

    for (int i = 0; i < 60; i++) begin
      mdu_op_e op;
      logic [31:0] a, b;
      int sel;
      op  = mdu_op_e'($urandom_range(1, 8));
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 40) - 20; b = $urandom_range(1, 9); end
      case (op)
        MFHI, MFLO: begin
          start = 1'b0; mdu_op = op;
          #1;
          chk("rnd/mf", mdu_result, (op == MFHI) ? m_hi : m_lo);
          tick();
        end
        MTHI, MTLO: do_mt(op, a, "rnd/mt");
        default:    do_compute(op, a, b, "rnd/cmp");
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
